random_delay_arm: RTL

Consumes the free-running 12-bit pseudo-random word from the LFSR stage and turns it into a randomized "go" instant for the reaction timer. On a start request it latches the random word, waits MIN_MS + r milliseconds, then raises `go` for the downstream reaction counter. A button press during the wait is flagged as a false start (`foul`).

---
 rtl/random_delay_arm_if.sv | 33 +++
 rtl/random_delay_arm.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/random_delay_arm_if.sv
// -----------------------------------------------------------------------------
// random_delay_arm_if
// Signal bundle between the reaction-timer controller and random_delay_arm.
//   r        [11:0] pseudo-random word from the LFSR stage
//   start           single-cycle start request
//   press           single-cycle player button press
//   busy            high while arming or showing GO
//   go              GO indication for the reaction counter
//   foul            false start flag (press while arming)
//   delay_ms [12:0] delay of the current/last round in ms
// modport master : drives r/start/press, observes the status outputs
// modport slave  : the random_delay_arm side
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface random_delay_arm_if;
  logic [11:0] r;
  logic        start;
  logic        press;
  logic        busy;
  logic        go;
  logic        foul;
  logic [12:0] delay_ms;

  modport master (
    output r, start, press,
    input  busy, go, foul, delay_ms
  );

  modport slave (
    input  r, start, press,
    output busy, go, foul, delay_ms
  );
endinterface

// File: rtl/random_delay_arm.sv
// -----------------------------------------------------------------------------
// random_delay_arm
// Turns a latched pseudo-random word into a randomized GO instant. An accepted
// start loads MIN_MS + r ms, a millisecond prescaler counts the wait down, and
// GO is raised when it runs out. A press while waiting is a false start.
//
// Ports:
//   clk50M  in   system clock
//   rst_n   in   asynchronous active-low reset
//   bus     slave modport of random_delay_arm_if (r/start/press in,
//                busy/go/foul/delay_ms out, all outputs registered)
// Parameters:
//   CLK_PER_MS  clock cycles per millisecond tick (>= 2)
//   MIN_MS      fixed minimum delay in ms (MIN_MS + 4095 must fit 13 bits)
//   TIMEOUT_MS  GO timeout in ms, active only with the macro below
// Optional feature macro: RANDOM_DELAY_ARM_TIMEOUT_EN
//   defined   : GO returns to IDLE after TIMEOUT_MS without a press
//   undefined : GO holds until press or reset
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module random_delay_arm #(
  parameter int CLK_PER_MS = 50000,
  parameter int MIN_MS     = 1000,
  parameter int TIMEOUT_MS = 3000
) (
  input  logic               clk50M,
  input  logic               rst_n,
  random_delay_arm_if.slave  bus
);

  localparam int              PW         = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [12:0]     MIN_MS_C   = 13'(MIN_MS);

  // Elaboration-time parameter sanity checks
  if (CLK_PER_MS < 2) begin : g_bad_clk_per_ms
    $error("random_delay_arm: CLK_PER_MS must be >= 2");
  end
  if ((MIN_MS < 0) || (MIN_MS + 4095 > 8191)) begin : g_bad_min_ms
    $error("random_delay_arm: MIN_MS + 4095 must fit in 13 bits");
  end
  if ((TIMEOUT_MS < 1) || (TIMEOUT_MS > 8191)) begin : g_bad_timeout_ms
    $error("random_delay_arm: TIMEOUT_MS must be 1..8191");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GO   = 2'd2,
    ST_FOUL = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PW-1:0]   r_presc;
  logic [12:0]     r_remain;
  logic [12:0]     r_delay_ms;
  logic            r_busy;
  logic            r_go;
  logic            r_foul;
  logic            w_busy;
  logic            w_go;
  logic            w_foul;
  logic            w_start_ok;
  logic            w_wrap;
  logic [12:0]     w_sum;

  // Only IDLE and FOUL accept a start; ARM/GO ignore it
  assign w_start_ok = bus.start && ((r_state == ST_IDLE) || (r_state == ST_FOUL));
  assign w_wrap     = (r_presc == PRESC_LAST);
  // 13-bit sum; parameter checks guarantee it cannot overflow
  assign w_sum      = MIN_MS_C + {1'b0, bus.r};

`ifdef RANDOM_DELAY_ARM_TIMEOUT_EN
  localparam logic [12:0] TIMEOUT_C = 13'(TIMEOUT_MS);
  logic [12:0] r_tmo;
  logic        w_tmo_expire;

  // Expiry is the wrap that would take the timeout count from 1 to 0
  assign w_tmo_expire = (r_state == ST_GO) && w_wrap && (r_tmo == 13'd1);

  // GO timeout counter: loaded on GO entry, decremented per ms tick in GO
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= 13'd0;
    end else if ((r_state != ST_GO) && (w_next_state == ST_GO)) begin
      r_tmo <= TIMEOUT_C;
    end else if ((r_state == ST_GO) && w_wrap && (r_tmo != 13'd0)) begin
      r_tmo <= r_tmo - 13'd1;
    end else begin
      r_tmo <= r_tmo;
    end
  end
`endif

  // State register
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; press has priority over the GO transition in ARM
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next_state = ST_ARM;
        else           w_next_state = ST_IDLE;
      end
      ST_ARM: begin
        if (bus.press)                             w_next_state = ST_FOUL;
        else if (r_remain == 13'd0)                w_next_state = ST_GO;
        else if (w_wrap && (r_remain == 13'd1))    w_next_state = ST_GO;
        else                                       w_next_state = ST_ARM;
      end
      ST_GO: begin
        if (bus.press)         w_next_state = ST_IDLE;
`ifdef RANDOM_DELAY_ARM_TIMEOUT_EN
        else if (w_tmo_expire) w_next_state = ST_IDLE;
`endif
        else                   w_next_state = ST_GO;
      end
      ST_FOUL: begin
        if (bus.start) w_next_state = ST_ARM;
        else           w_next_state = ST_FOUL;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs track the state
  always_comb begin
    w_busy = 1'b0;
    w_go   = 1'b0;
    w_foul = 1'b0;
    case (w_next_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        w_go   = 1'b0;
        w_foul = 1'b0;
      end
      ST_ARM: begin
        w_busy = 1'b1;
        w_go   = 1'b0;
        w_foul = 1'b0;
      end
      ST_GO: begin
        w_busy = 1'b1;
        w_go   = 1'b1;
        w_foul = 1'b0;
      end
      ST_FOUL: begin
        w_busy = 1'b0;
        w_go   = 1'b0;
        w_foul = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_go   = 1'b0;
        w_foul = 1'b0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_go   <= 1'b0;
      r_foul <= 1'b0;
    end else begin
      r_busy <= w_busy;
      r_go   <= w_go;
      r_foul <= w_foul;
    end
  end

  // Millisecond prescaler: restarts on accepted start, runs in ARM and GO
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_start_ok) begin
      r_presc <= '0;
    end else if ((r_state == ST_ARM) || (r_state == ST_GO)) begin
      r_presc <= w_wrap ? '0 : (r_presc + PW'(1));
    end else begin
      r_presc <= '0;
    end
  end

  // Remaining-ms counter and latched delay, both loaded only on accepted start
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_remain   <= 13'd0;
      r_delay_ms <= 13'd0;
    end else if (w_start_ok) begin
      r_remain   <= w_sum;
      r_delay_ms <= w_sum;
    end else if ((r_state == ST_ARM) && w_wrap && (r_remain != 13'd0)) begin
      r_remain   <= r_remain - 13'd1;
      r_delay_ms <= r_delay_ms;
    end else begin
      r_remain   <= r_remain;
      r_delay_ms <= r_delay_ms;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.go       = r_go;
  assign bus.foul     = r_foul;
  assign bus.delay_ms = r_delay_ms;

endmodule
